pattern_gen_multi: RTL and testbench

Parametrised, mode-selectable VGA test-pattern generator. It sits between the VGA timing block, which supplies `colPos`/`rowPos`, and the colour output pins. It replaces the fixed free-running XOR-scroll pattern with four patterns, frame-synchronous mode switching and a per-frame scroll speed. The output is registered and carries a frame marker, so downstream capture and overlay logic can align to frame boundaries.

---
 rtl/pattern_pkg.sv | 13 +
 rtl/frame_start_det.sv | 23 ++
 rtl/pattern_gen_multi.sv | 100 ++++++++++
 tb/tb_pattern_gen_multi.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared types for the VGA test-pattern generator and its frame helpers.
package pattern_pkg;

  localparam int POS_W = 10;

  typedef enum logic [1:0] {
    PAT_SCROLL  = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_mode_t;

endpackage

// File: rtl/frame_start_det.sv
// Flags the first cycle at position (0,0); a held (0,0) only counts once.
module frame_start_det
  import pattern_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] colPos,
  input  logic [POS_W-1:0] rowPos,
  output logic             frame_start
);

  logic is_zero;
  logic prev_zero_q;

  assign is_zero     = (colPos == '0) && (rowPos == '0);
  assign frame_start = is_zero && !prev_zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_zero_q <= 1'b0;
    else     prev_zero_q <= is_zero;
  end

endmodule

// File: rtl/pattern_gen_multi.sv
// Mode-selectable VGA test-pattern generator with frame-synchronous mode and
// scroll updates, one registered output stage and a frame marker.
module pattern_gen_multi
  import pattern_pkg::*;
#(
  parameter int                 H_ACTIVE    = 640,
  parameter int                 V_ACTIVE    = 480,
  parameter int                 COLOR_W     = 6,
  parameter int                 OFFSET_W    = 8,
  parameter logic [COLOR_W-1:0] SCROLL_MASK = '1,
  parameter int                 BAR_LOG2    = 6,
  parameter int                 SQUARE_LOG2 = 3,
  parameter logic [COLOR_W-1:0] FILL_COLOR  = COLOR_W'(6'b110000)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [POS_W-1:0]    colPos,
  input  logic [POS_W-1:0]    rowPos,
  input  pattern_mode_t       mode_req,
  input  logic [3:0]          speed,
  output logic                display_enable,
  output logic [COLOR_W-1:0]  color,
  output logic                frame_tick
);

  localparam int                REP   = COLOR_W / 3;
  localparam logic [POS_W-1:0] H_LIM = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_LIM = POS_W'(V_ACTIVE);

  logic                frame_start;
  pattern_mode_t       mode_q, mode_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [COLOR_W-1:0]  color_q, color_d;
  logic                de_q, de_d;
  logic                tick_q;

  logic [COLOR_W-1:0]  shift;
  logic [POS_W-1:0]    bar_sh, col_sq, row_sq;
  logic [2:0]          bar_idx;

  frame_start_det u_fsd (
    .clk         (clk),
    .rst         (rst),
    .colPos      (colPos),
    .rowPos      (rowPos),
    .frame_start (frame_start)
  );

  // Frame-start values are forwarded so pixel (0,0) already uses them.
  always_comb begin
    mode_d   = mode_q;
    offset_d = offset_q;
    if (frame_start) begin
      mode_d   = mode_req;
      offset_d = offset_q + OFFSET_W'(speed);
    end
  end

  assign shift   = offset_d[OFFSET_W-1 -: COLOR_W];
  assign bar_sh  = colPos >> BAR_LOG2;
  assign bar_idx = bar_sh[2:0];
  assign col_sq  = colPos >> SQUARE_LOG2;
  assign row_sq  = rowPos >> SQUARE_LOG2;

  always_comb begin
    de_d    = (colPos < H_LIM) && (rowPos < V_LIM);
    color_d = '0;
    if (de_d) begin
      case (mode_d)
        PAT_SCROLL:  color_d = ((colPos[COLOR_W-1:0] + shift) ^ rowPos[COLOR_W-1:0])
                               & SCROLL_MASK;
        PAT_BARS:    color_d = {{REP{bar_idx[2]}}, {REP{bar_idx[1]}}, {REP{bar_idx[0]}}};
        PAT_CHECKER: color_d = (col_sq[0] ^ row_sq[0]) ? '1 : '0;
        PAT_SOLID:   color_d = FILL_COLOR;
        default:     color_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= PAT_SCROLL;
      offset_q <= '0;
      color_q  <= '0;
      de_q     <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      offset_q <= offset_d;
      color_q  <= color_d;
      de_q     <= de_d;
      tick_q   <= frame_start;
    end
  end

  assign color          = color_q;
  assign display_enable = de_q;
  assign frame_tick     = tick_q;

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Directed bench for pattern_gen_multi with hand-computed expected pixels.
module tb_pattern_gen_multi;
  import pattern_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    colPos = '0;
  logic [9:0]    rowPos = '0;
  pattern_mode_t mode_req = PAT_SCROLL;
  logic [3:0]    speed = '0;
  logic          display_enable;
  logic [5:0]    color;
  logic          frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pattern_gen_multi dut (
    .clk            (clk),
    .rst            (rst),
    .colPos         (colPos),
    .rowPos         (rowPos),
    .mode_req       (mode_req),
    .speed          (speed),
    .display_enable (display_enable),
    .color          (color),
    .frame_tick     (frame_tick)
  );

  task automatic step(input logic [9:0] c, input logic [9:0] r);
    colPos = c;
    rowPos = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    colPos = 10'd0; rowPos = 10'd0; mode_req = PAT_SCROLL; speed = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (color !== 6'd0) begin n_err++; $display("FAIL rst_color got %0h want 0", color); end
    n_cmp++; if (display_enable !== 1'b0) begin n_err++; $display("FAIL rst_de got %0b want 0", display_enable); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL rst_tick got %0b want 0", frame_tick); end
    rst = 1'b0;
    // position already (0,0) at release: first clock is a frame start
    step(10'd0, 10'd0);
    n_cmp++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL rel00_tick got %0b want 1", frame_tick); end
    n_cmp++; if (color !== 6'd0) begin n_err++; $display("FAIL rel00_color got %0h want 0", color); end
  endtask

  task automatic test_scroll;
    step(10'd3, 10'd5);
    n_cmp++; if (color !== 6'd6) begin n_err++; $display("FAIL scroll35 color got %0h want 6", color); end
    n_cmp++; if (display_enable !== 1'b1) begin n_err++; $display("FAIL scroll35 de got %0b want 1", display_enable); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL scroll35 tick got %0b want 0", frame_tick); end
  endtask

  task automatic test_frame_scroll;
    speed = 4'd4;
    step(10'd0, 10'd0);
    n_cmp++; if (color !== 6'd1) begin n_err++; $display("FAIL fscroll00 color got %0h want 1", color); end
    n_cmp++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL fscroll00 tick got %0b want 1", frame_tick); end
    speed = 4'd0;
    step(10'd3, 10'd5);
    n_cmp++; if (color !== 6'd1) begin n_err++; $display("FAIL fscroll35 color got %0h want 1", color); end
  endtask

  task automatic test_bars_checker;
    mode_req = PAT_BARS;
    step(10'd1, 10'd1);
    step(10'd0, 10'd0);
    n_cmp++; if (color !== 6'd0 || frame_tick !== 1'b1) begin n_err++; $display("FAIL bars00 color/tick got %0h/%0b want 0/1", color, frame_tick); end
    step(10'd200, 10'd10);
    n_cmp++; if (color !== 6'b001111) begin n_err++; $display("FAIL bars200 color got %0h want 0f", color); end
    mode_req = PAT_CHECKER;
    step(10'd200, 10'd10);
    n_cmp++; if (color !== 6'b001111) begin n_err++; $display("FAIL bars_hold color got %0h want 0f", color); end
    step(10'd1, 10'd1);
    step(10'd0, 10'd0);
    n_cmp++; if (color !== 6'd0 || frame_tick !== 1'b1) begin n_err++; $display("FAIL chk00 color/tick got %0h/%0b want 0/1", color, frame_tick); end
    step(10'd8, 10'd0);
    n_cmp++; if (color !== 6'h3F) begin n_err++; $display("FAIL chk80 color got %0h want 3f", color); end
    step(10'd8, 10'd8);
    n_cmp++; if (color !== 6'h00) begin n_err++; $display("FAIL chk88 color got %0h want 0", color); end
  endtask

  task automatic test_mid_frame;
    mode_req = PAT_SOLID;
    step(10'd100, 10'd100);
    n_cmp++; if (color !== 6'h00) begin n_err++; $display("FAIL mid100 color got %0h want 0", color); end
    step(10'd8, 10'd0);
    n_cmp++; if (color !== 6'h3F) begin n_err++; $display("FAIL mid80 color got %0h want 3f", color); end
    step(10'd0, 10'd0);
    n_cmp++; if (color !== 6'b110000 || frame_tick !== 1'b1) begin n_err++; $display("FAIL solid00 color/tick got %0h/%0b want 30/1", color, frame_tick); end
    step(10'd639, 10'd479);
    n_cmp++; if (color !== 6'b110000 || display_enable !== 1'b1) begin n_err++; $display("FAIL solid_edge color/de got %0h/%0b want 30/1", color, display_enable); end
  endtask

  task automatic test_blanking;
    int ticks;
    step(10'd640, 10'd0);
    n_cmp++; if (color !== 6'd0 || display_enable !== 1'b0) begin n_err++; $display("FAIL blank_h color/de got %0h/%0b want 0/0", color, display_enable); end
    step(10'd0, 10'd480);
    n_cmp++; if (color !== 6'd0 || display_enable !== 1'b0) begin n_err++; $display("FAIL blank_v color/de got %0h/%0b want 0/0", color, display_enable); end
    step(10'd700, 10'd500);
    n_cmp++; if (color !== 6'd0 || display_enable !== 1'b0) begin n_err++; $display("FAIL blank_hv color/de got %0h/%0b want 0/0", color, display_enable); end
    step(10'd5, 10'd5);
    ticks = 0;
    for (int i = 0; i < 5; i++) begin
      step(10'd0, 10'd0);
      if (frame_tick === 1'b1) ticks++;
    end
    n_cmp++; if (ticks !== 1) begin n_err++; $display("FAIL held00 ticks got %0d want 1", ticks); end
  endtask

  task automatic test_offset_wrap;
    // offset is 4 here; 62 starts at speed 4 reach 252, the 63rd wraps to 0
    mode_req = PAT_SCROLL;
    speed = 4'd4;
    for (int k = 0; k < 61; k++) begin
      step(10'd1, 10'd1);
      step(10'd0, 10'd0);
    end
    step(10'd1, 10'd1);
    step(10'd0, 10'd0);
    n_cmp++; if (color !== 6'd63) begin n_err++; $display("FAIL off252 color got %0h want 3f", color); end
    step(10'd1, 10'd1);
    step(10'd0, 10'd0);
    n_cmp++; if (color !== 6'd0 || frame_tick !== 1'b1) begin n_err++; $display("FAIL offwrap color/tick got %0h/%0b want 0/1", color, frame_tick); end
    speed = 4'd0;
    step(10'd3, 10'd5);
    n_cmp++; if (color !== 6'd6) begin n_err++; $display("FAIL offwrap35 color got %0h want 6", color); end
  endtask

  task automatic test_reset_mid;
    mode_req = PAT_BARS;
    speed = 4'd8;
    step(10'd1, 10'd1);
    step(10'd0, 10'd0);
    step(10'd200, 10'd10);
    n_cmp++; if (color !== 6'b001111) begin n_err++; $display("FAIL pre_rst color got %0h want 0f", color); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (color !== 6'd0 || display_enable !== 1'b0 || frame_tick !== 1'b0) begin n_err++; $display("FAIL async_rst c/de/t got %0h/%0b/%0b want 0/0/0", color, display_enable, frame_tick); end
    @(posedge clk); #1;
    rst = 1'b0;
    step(10'd200, 10'd10);
    n_cmp++; if (color !== 6'd2) begin n_err++; $display("FAIL post_rst200 color got %0h want 2", color); end
    step(10'd3, 10'd5);
    n_cmp++; if (color !== 6'd6) begin n_err++; $display("FAIL post_rst35 color got %0h want 6", color); end
    step(10'd0, 10'd0);
    n_cmp++; if (color !== 6'd0 || frame_tick !== 1'b1) begin n_err++; $display("FAIL relatch00 color/tick got %0h/%0b want 0/1", color, frame_tick); end
    step(10'd200, 10'd10);
    n_cmp++; if (color !== 6'b001111) begin n_err++; $display("FAIL relatch200 color got %0h want 0f", color); end
  endtask

  initial begin
    test_reset;
    test_scroll;
    test_frame_scroll;
    test_bars_checker;
    test_mid_frame;
    test_blanking;
    test_offset_wrap;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
